// File: rtl/vscale_lsu_pkg.sv
// vscale_lsu_pkg: shared definitions for the vscale load/store unit.
// Holds the access-size encodings, the LSU FSM state encoding and the
// load/store lane-formatting helpers. The helpers operate on 64-bit
// values so that both XLEN=32 and XLEN=64 users can truncate the result.
package vscale_lsu_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_REQ  = 2'd1,
    LD_REQ  = 2'd2,
    LD_WAIT = 2'd3
  } lsu_state_e;

  // Extract the addressed bytes from an aligned memory word and extend them.
  function automatic logic [63:0] lsu_load_format(
    input logic [63:0] raw,
    input logic [2:0]  lane,
    input logic [1:0]  size,
    input logic        is_unsigned
  );
    logic [63:0] sh;
    sh = raw >> {lane, 3'b000};
    case (size)
      MEM_SIZE_B: lsu_load_format = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      MEM_SIZE_H: lsu_load_format = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      MEM_SIZE_W: lsu_load_format = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default:    lsu_load_format = sh;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane of the word.
  function automatic logic [63:0] lsu_store_data(
    input logic [63:0] data,
    input logic [1:0]  size
  );
    case (size)
      MEM_SIZE_B: lsu_store_data = {8{data[7:0]}};
      MEM_SIZE_H: lsu_store_data = {4{data[15:0]}};
      MEM_SIZE_W: lsu_store_data = {2{data[31:0]}};
      default:    lsu_store_data = data;
    endcase
  endfunction

  // Byte enables for a store of the given size starting at byte lane.
  function automatic logic [7:0] lsu_store_strb(
    input logic [1:0] size,
    input logic [2:0] lane
  );
    case (size)
      MEM_SIZE_B: lsu_store_strb = 8'h01 << lane;
      MEM_SIZE_H: lsu_store_strb = 8'h03 << lane;
      MEM_SIZE_W: lsu_store_strb = 8'h0F << lane;
      default:    lsu_store_strb = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/vscale_lsu_sbuf.sv
// vscale_lsu_sbuf: in-order posted-store FIFO with a word-address compare port.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   i_push, i_push_*         write a new entry at the tail
//   i_pop                    retire the head entry
//   o_head_*                 head entry contents (valid when !o_empty)
//   o_empty, o_full          occupancy flags
//   i_cmp_waddr, o_match     any valid entry holding this word address
module vscale_lsu_sbuf
  import vscale_lsu_pkg::*;
#(
  parameter int WA_W   = 30,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [WA_W-1:0]      i_push_waddr,
  input  logic [XLEN-1:0]      i_push_wdata,
  input  logic [XLEN/8-1:0]    i_push_wstrb,
  input  logic                 i_pop,
  output logic [WA_W-1:0]      o_head_waddr,
  output logic [XLEN-1:0]      o_head_wdata,
  output logic [XLEN/8-1:0]    o_head_wstrb,
  output logic                 o_empty,
  output logic                 o_full,
  input  logic [WA_W-1:0]      i_cmp_waddr,
  output logic                 o_match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WA_W-1:0]   r_waddr [DEPTH];
  logic [XLEN-1:0]   r_wdata [DEPTH];
  logic [XLEN/8-1:0] r_wstrb [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (i_push && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_push && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Payload needs no reset; only the per-entry valid bits gate its use.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_waddr[r_wr_ptr] <= i_push_waddr;
      r_wdata[r_wr_ptr] <= i_push_wdata;
      r_wstrb[r_wr_ptr] <= i_push_wstrb;
    end
  end

  // Push and pop never target the same slot: pop needs count>0, push needs count<DEPTH.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          r_valid[gi] <= 1'b0;
        end else if (i_push && (r_wr_ptr == PTR_W'(gi))) begin
          r_valid[gi] <= 1'b1;
        end else if (i_pop && (r_rd_ptr == PTR_W'(gi))) begin
          r_valid[gi] <= 1'b0;
        end
      end
      assign w_hit[gi] = r_valid[gi] && (r_waddr[gi] == i_cmp_waddr);
    end
  endgenerate

  assign o_match      = |w_hit;
  assign o_head_waddr = r_waddr[r_rd_ptr];
  assign o_head_wdata = r_wdata[r_rd_ptr];
  assign o_head_wstrb = r_wstrb[r_rd_ptr];
  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CNT_W'(DEPTH));

endmodule

// File: rtl/vscale_lsu.sv
// vscale_lsu: load/store unit between the pipeline memory stage and dmem.
// Posted stores go to a DEPTH-entry buffer; loads may overtake buffered
// stores to other words, and are blocked while a store to the same word
// is still buffered.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   i_req_* / o_req_ready           pipeline request (valid/ready)
//   o_resp_valid/rdata/err          one-cycle load response or error pulse
//   i_fence_valid / o_fence_done    drain request / buffer empty and idle
//   o_mem_req_* / i_mem_req_ready   memory request channel
//   i_mem_rvalid / i_mem_rdata      memory load return
module vscale_lsu
  import vscale_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_wen,
  input  logic [1:0]          i_req_size,
  input  logic                i_req_unsigned,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [XLEN-1:0]     i_req_wdata,
  output logic                o_resp_valid,
  output logic [XLEN-1:0]     o_resp_rdata,
  output logic                o_resp_err,
  input  logic                i_fence_valid,
  output logic                o_fence_done,
  output logic                o_mem_req_valid,
  input  logic                i_mem_req_ready,
  output logic                o_mem_wen,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [XLEN-1:0]     o_mem_wdata,
  output logic [XLEN/8-1:0]   o_mem_wstrb,
  input  logic                i_mem_rvalid,
  input  logic [XLEN-1:0]     i_mem_rdata
);

  localparam int STRB_W = XLEN / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int WA_W   = ADDR_W - LANE_W;

  lsu_state_e r_state, w_state_next;

  logic              r_mem_wen;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic [1:0]        r_ld_size;
  logic              r_ld_unsigned;
  logic [2:0]        r_ld_lane;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [XLEN-1:0]   r_resp_rdata;

  logic [WA_W-1:0]   w_req_waddr, w_head_waddr;
  logic [XLEN-1:0]   w_head_wdata;
  logic [STRB_W-1:0] w_head_wstrb;
  logic              w_empty, w_full, w_match;
  logic [2:0]        w_align_mask, w_req_lane;
  logic              w_err, w_resp_busy, w_st_ready, w_ld_ready;
  logic              w_accept, w_push, w_ld_go, w_pop;

  assign w_req_waddr  = i_req_addr[ADDR_W-1:LANE_W];
  assign w_req_lane   = 3'(i_req_addr[LANE_W-1:0]);
  assign w_align_mask = 3'((4'd1 << i_req_size) - 4'd1);
  assign w_err        = ((XLEN == 32) && (i_req_size == MEM_SIZE_D)) ||
                        (|(i_req_addr[2:0] & w_align_mask));

  // A faulting store would pulse the response in the same cycle as a load
  // return being captured; hold it off for that one cycle.
  assign w_resp_busy = (r_state == LD_WAIT) && i_mem_rvalid;
  assign w_st_ready  = !i_fence_valid && !w_full && !(w_err && w_resp_busy);
  assign w_ld_ready  = !i_fence_valid && (r_state == IDLE) && !w_match;
  assign o_req_ready = i_req_wen ? w_st_ready : w_ld_ready;

  assign w_accept = i_req_valid && o_req_ready;
  assign w_push   = w_accept && i_req_wen && !w_err;
  assign w_ld_go  = w_accept && !i_req_wen && !w_err;
  assign w_pop    = (r_state == ST_REQ) && i_mem_req_ready;

  vscale_lsu_sbuf #(
    .WA_W  (WA_W),
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_sbuf (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_waddr (w_req_waddr),
    .i_push_wdata (XLEN'(lsu_store_data(64'(i_req_wdata), i_req_size))),
    .i_push_wstrb (STRB_W'(lsu_store_strb(i_req_size, w_req_lane))),
    .i_pop        (w_pop),
    .o_head_waddr (w_head_waddr),
    .o_head_wdata (w_head_wdata),
    .o_head_wstrb (w_head_wstrb),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .i_cmp_waddr  (w_req_waddr),
    .o_match      (w_match)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic: a newly accepted load beats a pending store drain.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_ld_go)       w_state_next = LD_REQ;
        else if (!w_empty) w_state_next = ST_REQ;
      end
      ST_REQ:  if (i_mem_req_ready) w_state_next = IDLE;
      LD_REQ:  if (i_mem_req_ready) w_state_next = LD_WAIT;
      LD_WAIT: if (i_mem_rvalid)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_mem_req_valid = (r_state == ST_REQ) || (r_state == LD_REQ);
    o_fence_done    = w_empty && (r_state == IDLE);
  end

  // Memory request fields are loaded only when leaving IDLE, so they hold
  // steady for the whole request phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_wen     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_ld_size     <= MEM_SIZE_B;
      r_ld_unsigned <= 1'b0;
      r_ld_lane     <= '0;
    end else if (r_state == IDLE) begin
      if (w_ld_go) begin
        r_mem_wen     <= 1'b0;
        r_mem_addr    <= {w_req_waddr, {LANE_W{1'b0}}};
        r_mem_wdata   <= '0;
        r_mem_wstrb   <= '0;
        r_ld_size     <= i_req_size;
        r_ld_unsigned <= i_req_unsigned;
        r_ld_lane     <= w_req_lane;
      end else if (!w_empty) begin
        r_mem_wen   <= 1'b1;
        r_mem_addr  <= {w_head_waddr, {LANE_W{1'b0}}};
        r_mem_wdata <= w_head_wdata;
        r_mem_wstrb <= w_head_wstrb;
      end
    end
  end

  // Response register: one-cycle pulse for a load return or a faulting request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (w_accept && w_err) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= 1'b1;
        r_resp_rdata <= '0;
      end else if (w_resp_busy) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= XLEN'(lsu_load_format(64'(i_mem_rdata), r_ld_lane,
                                              r_ld_size, r_ld_unsigned));
      end
    end
  end

  assign o_mem_wen    = r_mem_wen;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_wstrb  = r_mem_wstrb;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_vscale_lsu.sv
// tb_vscale_lsu: directed self-checking bench for vscale_lsu (XLEN=32, DEPTH=4).
module tb_vscale_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        fence_valid, fence_done;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vscale_lsu #(.XLEN(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_wen       (req_wen),
    .i_req_size      (req_size),
    .i_req_unsigned  (req_unsigned),
    .i_req_addr      (req_addr),
    .i_req_wdata     (req_wdata),
    .o_resp_valid    (resp_valid),
    .o_resp_rdata    (resp_rdata),
    .o_resp_err      (resp_err),
    .i_fence_valid   (fence_valid),
    .o_fence_done    (fence_done),
    .o_mem_req_valid (mem_req_valid),
    .i_mem_req_ready (mem_req_ready),
    .o_mem_wen       (mem_wen),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .o_mem_wstrb     (mem_wstrb),
    .i_mem_rvalid    (mem_rvalid),
    .i_mem_rdata     (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic wen, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    #1;
  endtask

  // Full load transaction from IDLE with no hazard, memory accepting at once.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] rdata, input logic [31:0] exp);
    set_req(1'b0, size, uns, addr, 32'd0);
    check({tag, "_ready"}, req_ready, 1);
    tick;
    req_valid = 1'b0;
    check({tag, "_mreq"}, mem_req_valid, 1);
    check({tag, "_maddr"}, mem_addr, addr & 32'hFFFF_FFFC);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    tick;
    mem_rvalid = 1'b0;
    check({tag, "_rvalid"}, resp_valid, 1);
    check({tag, "_rdata"}, resp_rdata, exp);
  endtask

  // Faulting request: error pulse next cycle, no memory traffic, nothing buffered.
  task automatic do_err(input string tag, input logic wen, input logic [1:0] size,
                        input logic [31:0] addr);
    set_req(wen, size, 1'b0, addr, 32'h1234_5678);
    check({tag, "_ready"}, req_ready, 1);
    tick;
    req_valid = 1'b0;
    check({tag, "_rvalid"}, resp_valid, 1);
    check({tag, "_err"}, resp_err, 1);
    check({tag, "_rdata"}, resp_rdata, 0);
    check({tag, "_mreq"}, mem_req_valid, 0);
    tick;
    check({tag, "_pulse"}, resp_valid, 0);
    check({tag, "_mreq2"}, mem_req_valid, 0);
    check({tag, "_fdone"}, fence_done, 1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];
  logic [3:0]  exp_strb [4];

  initial begin
    reset = 1'b1;
    req_valid = 0; req_wen = 0; req_size = 0; req_unsigned = 0;
    req_addr = 0; req_wdata = 0; fence_valid = 0;
    mem_req_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    tick; tick;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mreq", mem_req_valid, 0);
    check("rst_maddr", mem_addr, 0);
    check("rst_mwstrb", mem_wstrb, 0);
    check("rst_fence_done", fence_done, 1);
    reset = 1'b0;
    tick;

    // Buffered store, then a load to another word overtakes it.
    set_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    check("t1_st_ready", req_ready, 1);
    tick;
    set_req(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
    check("t1_ld_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("t1_ld_first", mem_wen, 0);
    check("t1_ld_addr", mem_addr, 32'h200);
    tick; tick;
    check("t1_stall_valid", mem_req_valid, 1);
    check("t1_stall_addr", mem_addr, 32'h200);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    tick;
    mem_rvalid = 1'b0;
    check("t1_resp", resp_rdata, 32'h11223344);
    tick;
    check("t1_resp_pulse", resp_valid, 0);
    check("t1_st_wen", mem_wen & mem_req_valid, 1);
    check("t1_st_addr", mem_addr, 32'h100);
    check("t1_st_wdata", mem_wdata, 32'hDEADBEEF);
    check("t1_st_wstrb", mem_wstrb, 4'hF);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    check("t1_fence_done", fence_done, 1);

    // Stray memory return outside LD_WAIT is ignored.
    mem_rvalid = 1'b1;
    tick;
    mem_rvalid = 1'b0;
    check("stray_rvalid", resp_valid, 0);

    // Store-to-load hazard on the same word.
    set_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h7F);
    tick;
    set_req(1'b0, 2'd0, 1'b0, 32'h100, 32'd0);
    check("t2_hazard_ready", req_ready, 0);
    tick;
    check("t2_hazard_ready2", req_ready, 0);
    check("t2_st_addr", mem_addr, 32'h100);
    check("t2_st_wstrb", mem_wstrb, 4'b1000);
    check("t2_st_wdata", mem_wdata, 32'h7F7F7F7F);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    check("t2_ld_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("t2_ld_wen", mem_wen, 0);
    check("t2_ld_addr", mem_addr, 32'h100);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hAABBCC7F;
    tick;
    mem_rvalid = 1'b0;
    check("t2_resp_valid", resp_valid, 1);
    check("t2_resp_rdata", resp_rdata, 32'h0000007F);

    // Sign extension.
    do_load("t3_lh",  32'h102, 2'd1, 1'b0, 32'h80001234, 32'hFFFF8000);
    do_load("t3_lhu", 32'h102, 2'd1, 1'b1, 32'h80001234, 32'h00008000);
    do_load("t3_lb3", 32'h103, 2'd0, 1'b0, 32'h80001234, 32'hFFFFFF80);

    // Misalignment and illegal size.
    do_err("t4_lw_mis", 1'b0, 2'd2, 32'h101);
    do_err("t4_ld_d",   1'b0, 2'd3, 32'h100);
    do_err("t4_sh_mis", 1'b1, 2'd1, 32'h101);

    // Full buffer, then fence drain in order.
    exp_addr[0] = 32'h10; exp_data[0] = 32'hA0A0A0A0; exp_strb[0] = 4'hF;
    exp_addr[1] = 32'h20; exp_data[1] = 32'h5A5A5A5A; exp_strb[1] = 4'b0010;
    exp_addr[2] = 32'h30; exp_data[2] = 32'hBEEFBEEF; exp_strb[2] = 4'b1100;
    exp_addr[3] = 32'h40; exp_data[3] = 32'h01234567; exp_strb[3] = 4'hF;
    set_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hA0A0A0A0); tick;
    set_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h5A);       tick;
    set_req(1'b1, 2'd1, 1'b0, 32'h32, 32'hBEEF);     tick;
    set_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h01234567);
    check("t5_4th_ready", req_ready, 1);
    tick;
    set_req(1'b1, 2'd2, 1'b0, 32'h50, 32'h0);
    check("t5_full_ready", req_ready, 0);
    req_valid = 1'b0;
    fence_valid = 1'b1;
    set_req(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
    check("t5_fence_blocks", req_ready, 0);
    req_valid = 1'b0;
    check("t5_not_done", fence_done, 0);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit got;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        if (mem_req_valid && mem_wen) begin
          check($sformatf("t5_drain%0d_addr", k), mem_addr, exp_addr[k]);
          check($sformatf("t5_drain%0d_data", k), mem_wdata, exp_data[k]);
          check($sformatf("t5_drain%0d_strb", k), mem_wstrb, exp_strb[k]);
          got = 1;
        end
        tick;
      end
      if (!got) check($sformatf("t5_drain%0d_timeout", k), 0, 1);
    end
    mem_req_ready = 1'b0;
    check("t5_fence_done", fence_done, 1);
    fence_valid = 1'b0;
    tick;

    // Reset while a load waits for data and a store is buffered.
    set_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    tick;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    set_req(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
    check("t6_st_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    check("t6_pre_done", fence_done, 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick;
    mem_rvalid = 1'b0;
    check("t6_no_resp", resp_valid, 0);
    check("t6_fence_done", fence_done, 1);
    tick;
    check("t6_no_drain", mem_req_valid, 0);
    check("t6_no_resp2", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vscale_lsu.md
# vscale_lsu

Parametrised load/store unit between the vscale pipeline's memory-stage outputs and the data-memory port. It replaces the fixed 32-bit, blocking, single-access dmem path with an XLEN-generic unit that has these features:
- a DEPTH-entry in-order posted-store buffer;
- byte-strobe generation;
- misalignment detection;
- load-versus-buffered-store hazard blocking;
- a fence/drain handshake.

Loads may overtake older buffered stores to different words.

## Interface
- XLEN, 32: data width; 32 or 64.
- ADDR_W, 32: address width.
- DEPTH, 4: store-buffer entries; power of two, ≥2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_wen  in  1  1=store, 0=load.
- req_size  in  2  0=B, 1=H, 2=W, 3=D (D legal only when XLEN=64).
- req_unsigned  in  1  zero-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  one-cycle load response / error pulse.
- resp_rdata  out  XLEN  extended load data.
- resp_err  out  1  misaligned or illegal-size access.
- fence_valid  in  1  level; drain request.
- fence_done  out  1  buffer empty and FSM IDLE.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_wen  out  1  store request.
- mem_addr  out  ADDR_W  address, aligned to XLEN/8.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_wstrb  out  XLEN/8  byte enables.
- mem_rvalid  in  1  load data return.
- mem_rdata  in  XLEN  raw aligned word.

## Operation
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT.
- IDLE:
  - load accepted → LD_REQ;
  - else buffer non-empty → ST_REQ;
  - else stay.
- ST_REQ: drives the head entry; on mem_req_ready, pop the head and go to IDLE.
- LD_REQ: drives the registered load; on mem_req_ready → LD_WAIT.
- LD_WAIT: on mem_rvalid → IDLE; the response is formatted and registered.
- mem_req_valid=1 exactly in ST_REQ and LD_REQ. All mem_* outputs stay stable until the handshake.
- Misaligned access: addr not a multiple of 2^req_size. Illegal access: size 3 with XLEN=32.
  - Accepted whenever req_ready.
  - Produces resp_valid with resp_err=1 and resp_rdata=0 the next cycle.
  - No memory access and no buffer write.
- Store acceptance: req_ready = !fence_valid && count<DEPTH. A push simultaneous with a pop is allowed.
  - Entry = {word address, lane-replicated data, strobe}. Stores produce no response.
- Load acceptance: req_ready = !fence_valid && state==IDLE && no valid buffer entry whose word address (addr[ADDR_W-1:log2(XLEN/8)]) equals req_addr's word address.
  - req_ready depends combinationally on req_addr/req_wen.
- Load formatting: shift mem_rdata right by 8·addr lane bits, mask to size, then sign-extend unless req_unsigned. Size/unsigned/lane are captured at acceptance.
- Store formatting:
  - B: data replicated ×(XLEN/8), strobe 1<<lane.
  - H: data replicated, strobe 2'b11<<lane.
  - W: data replicated, strobe 4'hF<<lane.
  - D: strobe all ones.
- mem_rvalid outside LD_WAIT is ignored.
- Loads complete in order; at most one load is outstanding.

## Timing
- Reset values:
  - state IDLE; buffer pointers and count 0;
  - resp_valid 0, resp_err 0, resp_rdata 0;
  - mem_req_valid 0, mem_wen 0, mem_addr 0, mem_wdata 0, mem_wstrb 0;
  - fence_done 1 (combinational).
- Load accepted in cycle N → mem_req_valid at N+1. Handshake at cycle H → earliest mem_rvalid at H+1. mem_rvalid at R → resp_valid at R+1. Minimum load latency is 3 cycles.
- Error response at N+1.
- Store accepted at N → earliest mem_req_valid at N+1 when IDLE.
- Load and store-drain both ready in IDLE: the load wins.
- Reset mid-transaction drops the outstanding load and all buffered stores.
- fence_done = (count==0 && state==IDLE). fence_valid blocks new requests until it is deasserted.

## Structure
- Shared package holds:
  - size encodings (MEM_SIZE_B/H/W/D);
  - FSM state encoding;
  - load-format and store-format functions, reused by any future cache.
- Sub-module vscale_lsu_sbuf holds the DEPTH-entry FIFO with per-entry word-address compare port (match output). The FSM, formatting and response register live in vscale_lsu.

## Test plan
- **Buffered store then load, different word.** SW 0xDEADBEEF @0x100, then LW @0x200 with mem_req_ready held 0 for 2 cycles.
  - The load issues first (IDLE priority).
  - The store drains afterward with wstrb=4'hF.
- **Store-to-load hazard.** SB 0x7F @0x103, then LB @0x100.
  - req_ready stays 0 until the store drains with wstrb=4'b1000 and wdata=0x7F7F7F7F.
  - The load returns 0x7F sign-extended from mem_rdata lane 0.
- **Sign extension.** LH @0x102 with mem_rdata=0x80001234 → resp_rdata=0xFFFF8000. LHU → 0x00008000.
- **Misalignment.** LW @0x101 → resp_valid with resp_err=1 one cycle later, and mem_req_valid stays 0. With XLEN=32, size 3 → resp_err=1.
- **Full buffer and fence.** DEPTH stores with mem_req_ready=0 → req_ready drops after the 4th. Then raise fence_valid and release mem_req_ready → 4 drains in order, then fence_done=1.
- **Reset during LD_WAIT.** Assert reset, then a late mem_rvalid arrives → resp_valid stays 0, count=0, fence_done=1.
